// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial adder and its bench.
package serial_arith_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single combinational full-adder cell; the only arithmetic in the serial datapath.
module fa_cell
    import serial_arith_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = maj3(x, y, ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial a + b + cin, LSB first, one full-adder cell over WIDTH cycles.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               w_s;
    logic               w_co;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_nxt;

    fa_cell u_fa (
        .x  (r_a_sr[0]),
        .y  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_nxt = StShift;
            StShift: if (w_last) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Operands are captured only on an accepted start, so input changes while busy are inert.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end
                end
                StShift: begin
                    r_carry <= w_co;
                    r_acc   <= w_acc_nxt;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum  <= w_acc_nxt;
                        r_cout <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != StIdle);
    assign done = (r_state == StDone);
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder at WIDTH=4 and WIDTH=8.
module tb_serial_adder;
    import serial_arith_pkg::*;

    localparam int unsigned W4 = WIDTH_DEFAULT;
    localparam int unsigned W8 = 8;
    typedef logic [W8:0] res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start4, cin4, busy4, done4, cout4;
    logic [W4-1:0] a4, b4, sum4;
    logic          start8, cin8, busy8, done8, cout8;
    logic [W8-1:0] a8, b8, sum8;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_start4 = 0;
    int   n_start8 = 0;
    int   n_done4  = 0;
    int   n_done8  = 0;
    res_t q4[$];
    res_t q8[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    serial_adder #(.WIDTH(W8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    always @(posedge clk) begin
        if (done4 === 1'b1) n_done4++;
        if (done8 === 1'b1) n_done8++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Present operands, record the expected sum, and let the next rising edge sample start.
    task automatic drive_start(input int sel, input logic [W8-1:0] a, input logic [W8-1:0] b,
                               input logic ci, input bit hold);
        if (sel == 4) begin
            a4 = a[W4-1:0];
            b4 = b[W4-1:0];
            cin4 = ci;
            start4 = 1'b1;
            q4.push_back(res_t'(a[W4-1:0]) + res_t'(b[W4-1:0]) + res_t'(ci));
            n_start4++;
        end else begin
            a8 = a;
            b8 = b;
            cin8 = ci;
            start8 = 1'b1;
            q8.push_back(res_t'(a) + res_t'(b) + res_t'(ci));
            n_start8++;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (sel == 4) start4 = 1'b0;
            else start8 = 1'b0;
        end
    endtask

    // Called just after the accepting edge; lat counts edges from there to done (-1 on timeout).
    task automatic wait_done(input int sel, output int lat, output res_t got);
        int j = 0;
        lat = -1;
        while (lat < 0 && j < 40) begin
            @(negedge clk);
            if ((sel == 4 && done4 === 1'b1) || (sel == 8 && done8 === 1'b1)) lat = j;
            j++;
        end
        got = (sel == 4) ? res_t'({cout4, sum4}) : {cout8, sum8};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy4, done4} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ctrl4: busy/done=%b required 00", {busy4, done4});
        end
        n_checks++;
        if ({cout4, sum4} !== '0) begin
            n_errors++;
            $display("FAIL reset_result4: got %h required 0", {cout4, sum4});
        end
        n_checks++;
        if ({busy8, done8} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ctrl8: busy/done=%b required 00", {busy8, done8});
        end
        n_checks++;
        if ({cout8, sum8} !== '0) begin
            n_errors++;
            $display("FAIL reset_result8: got %h required 0", {cout8, sum8});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy4 !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_start: busy=%b required 0", busy4);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va[4] = '{4'b1101, 4'b1001, 4'b1111, 4'b0000};
        logic [3:0] vb[4] = '{4'b1011, 4'b1111, 4'b0000, 4'b0000};
        logic       vc[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        res_t       want[4] = '{9'h018, 9'h019, 9'h010, 9'h000};
        for (int i = 0; i < 4; i++) begin
            int   lat;
            res_t got;
            res_t exp;
            drive_start(4, W8'(va[i]), W8'(vb[i]), vc[i], 1'b0);
            wait_done(4, lat, got);
            exp = (q4.size() > 0) ? q4.pop_front() : 'x;
            n_checks++;
            if (got !== exp || got !== want[i]) begin
                n_errors++;
                $display("FAIL vec%0d_result: got %h required %h", i, got, want[i]);
            end
            n_checks++;
            if (lat != int'(W4) || busy4 !== 1'b1) begin
                n_errors++;
                $display("FAIL vec%0d_latency: lat=%0d busy=%b required %0d/1", i, lat, busy4, W4);
            end
            @(negedge clk);
            n_checks++;
            if ({busy4, done4} !== 2'b00 || {cout4, sum4} !== want[i][W4:0]) begin
                n_errors++;
                $display("FAIL vec%0d_after_done: busy/done=%b result=%h required 00/%h",
                         i, {busy4, done4}, {cout4, sum4}, want[i][W4:0]);
            end
        end
    endtask

    task automatic test_start_during_busy();
        int   d0 = n_done4;
        int   lat;
        res_t got;
        res_t exp;
        drive_start(4, W8'(3), W8'(5), 1'b0, 1'b1);
        a4 = 4'hf;
        b4 = 4'hf;
        cin4 = 1'b1;
        wait_done(4, lat, got);
        exp = (q4.size() > 0) ? q4.pop_front() : 'x;
        n_checks++;
        if (got !== exp || lat != int'(W4)) begin
            n_errors++;
            $display("FAIL busy_first_capture: got %h lat=%0d required %h lat=%0d", got, lat, exp, W4);
        end
        @(negedge clk);
        n_checks++;
        if ({busy4, done4} !== 2'b00) begin
            n_errors++;
            $display("FAIL busy_start_in_done: busy/done=%b required 00", {busy4, done4});
        end
        q4.push_back(res_t'(31));
        n_start4++;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done(4, lat, got);
        exp = (q4.size() > 0) ? q4.pop_front() : 'x;
        n_checks++;
        if (got !== exp || lat != int'(W4)) begin
            n_errors++;
            $display("FAIL busy_second_op: got %h lat=%0d required %h lat=%0d", got, lat, exp, W4);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (n_done4 - d0 != 2) begin
            n_errors++;
            $display("FAIL busy_done_count: got %0d required 2", n_done4 - d0);
        end
    endtask

    task automatic test_reset_abort();
        int   d0 = n_done4;
        int   lat;
        res_t got;
        res_t exp;
        drive_start(4, W8'(13), W8'(11), 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q4.delete();
        n_start4--;
        @(negedge clk);
        n_checks++;
        if ({busy4, done4, cout4, sum4} !== '0) begin
            n_errors++;
            $display("FAIL abort_clear: busy/done/cout/sum=%b required all 0",
                     {busy4, done4, cout4, sum4});
        end
        repeat (8) @(negedge clk);
        n_checks++;
        if (n_done4 != d0) begin
            n_errors++;
            $display("FAIL abort_no_done: done pulses=%0d required 0", n_done4 - d0);
        end
        drive_start(4, W8'(6), W8'(7), 1'b1, 1'b0);
        wait_done(4, lat, got);
        exp = (q4.size() > 0) ? q4.pop_front() : 'x;
        n_checks++;
        if (got !== exp || got !== res_t'(14) || lat != int'(W4)) begin
            n_errors++;
            $display("FAIL abort_recover: got %h lat=%0d required 00e lat=%0d", got, lat, W4);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back(input int sel);
        int d0 = (sel == 4) ? n_done4 : n_done8;
        int s0 = (sel == 4) ? n_start4 : n_start8;
        int w  = (sel == 4) ? int'(W4) : int'(W8);
        for (int i = 0; i < 1000; i++) begin
            int   lat;
            res_t got;
            res_t exp;
            drive_start(sel, W8'($urandom), W8'($urandom), 1'($urandom), 1'b0);
            wait_done(sel, lat, got);
            if (sel == 4) exp = (q4.size() > 0) ? q4.pop_front() : 'x;
            else exp = (q8.size() > 0) ? q8.pop_front() : 'x;
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL b2b%0d_op%0d_result: got %h required %h", sel, i, got, exp);
            end
            n_checks++;
            if (lat != w) begin
                n_errors++;
                $display("FAIL b2b%0d_op%0d_latency: got %0d required %0d", sel, i, lat, w);
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (sel == 4 ? (n_done4 - d0 != n_start4 - s0) : (n_done8 - d0 != n_start8 - s0)) begin
            n_errors++;
            $display("FAIL b2b%0d_done_count: done=%0d required %0d", sel,
                     (sel == 4 ? n_done4 : n_done8) - d0, (sel == 4 ? n_start4 : n_start8) - s0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start4 = 1'b0;
        a4 = '0;
        b4 = '0;
        cin4 = 1'b0;
        start8 = 1'b0;
        a8 = '0;
        b8 = '0;
        cin8 = 1'b0;
        test_reset();
        test_vectors();
        test_start_during_busy();
        test_reset_abort();
        test_back_to_back(4);
        test_back_to_back(8);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
